// File: rtl/axil_cmd_arbiter.sv
// Shares one AXI-Lite master command port among NUM_REQ requesters, one transaction in flight.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module axil_cmd_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                  resp_done,
    output logic [AXI_DATA_WIDTH-1:0]           resp_rdata,
    output logic [1:0]                          resp_error,
    output logic                                wr_valid,
    output logic [AXI_ADDR_WIDTH-1:0]           wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]           wr_data,
    input  logic                                wr_ready,
    input  logic                                wr_done,
    input  logic [1:0]                          wr_error,
    output logic                                rd_valid,
    output logic [AXI_ADDR_WIDTH-1:0]           rd_addr,
    input  logic                                rd_ready,
    input  logic                                rd_done,
    input  logic [AXI_DATA_WIDTH-1:0]           rd_data,
    input  logic [1:0]                          rd_error
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ = NUM_REQ;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] grant_idx, owner;
    logic          any_req, found;
    logic          grant_en, issue_ack, done_ack, clr_valid;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    assign any_req = |req_valid;

`ifdef AXIL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] rr_ptr;
    logic [IW:0]   cand;

    // Scan rr_ptr+1 .. rr_ptr+NUM_REQ with wrap; the first requester seen wins.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ))
                cand = cand - (IW+1)'(NUM_REQ);
            if (!found && req_valid[cand[IW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d   = state;
        grant_en  = 1'b0;
        issue_ack = 1'b0;
        done_ack  = 1'b0;
        clr_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_en = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_we ? wr_ready : rd_ready) begin
                    issue_ack = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_we ? wr_done : rd_done) begin
                    done_ack = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                clr_valid = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_ready  <= '0;
            resp_done  <= '0;
            resp_rdata <= '0;
            resp_error <= '0;
            wr_valid   <= 1'b0;
            rd_valid   <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            owner      <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rr_ptr     <= IW'(NUM_REQ - 1);
`endif
        end else begin
            req_ready <= '0;
            resp_done <= '0;
            if (grant_en) begin
                req_ready[grant_idx] <= 1'b1;
                owner     <= grant_idx;
                cmd_we    <= req_we[grant_idx];
                cmd_addr  <= req_addr[grant_idx*AW +: AW];
                cmd_wdata <= req_wdata[grant_idx*DW +: DW];
                wr_valid  <= req_we[grant_idx];
                rd_valid  <= ~req_we[grant_idx];
`ifndef AXIL_ARB_FIXED_PRIO_EN
                rr_ptr    <= grant_idx;
`endif
            end
            if (issue_ack || clr_valid) begin
                wr_valid <= 1'b0;
                rd_valid <= 1'b0;
            end
            if (done_ack) begin
                resp_done[owner] <= 1'b1;
                resp_error       <= cmd_we ? wr_error : rd_error;
                if (!cmd_we)
                    resp_rdata <= rd_data;
            end
        end
    end

    assign wr_addr = cmd_addr;
    assign rd_addr = cmd_addr;
    assign wr_data = cmd_wdata;

endmodule

// File: doc/axil_cmd_arbiter.md
Name: axil_cmd_arbiter

Overview:
- Shares one AXI-Lite master command port (wr_*/rd_* handshake side) between NUM_REQ requesters, e.g. the UART command decoder, a debug port and an init sequencer.
- Round-robin arbitration with exactly one transaction outstanding at a time.
- Latches the winner's command, sequences the master's valid/ready/done handshake, and returns completion, read data and response to the winner only.

Parameters:
- NUM_REQ, 3, number of requesters, 2..8
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-cycle pulse: command accepted
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*AXI_ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*AXI_DATA_WIDTH  packed write data
- resp_done  out  NUM_REQ  one-cycle completion pulse to the owning requester
- resp_rdata  out  AXI_DATA_WIDTH  read data, valid with resp_done
- resp_error  out  2  AXI resp code, valid with resp_done
- wr_valid / wr_addr / wr_data  out  1/AW/DW  to master write command
- wr_ready, wr_done  in  1  from master
- wr_error  in  2  from master
- rd_valid / rd_addr  out  1/AW  to master read command
- rd_ready, rd_done  in  1  from master
- rd_data  in  DW  from master
- rd_error  in  2  from master

Behaviour:
- Clocking and reset: single clock, aclk. Reset is asynchronous, active-low (aresetn).
- Reset values: all outputs 0; state IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Search req_valid starting at rr_ptr+1, wrapping modulo NUM_REQ; the first set bit wins (index g).
  - On a win, at the same edge: latch we/addr/wdata of g; set req_ready[g]=1 for one cycle; rr_ptr<=g; assert wr_valid if we=1, else rd_valid; go to ISSUE.
  - No request: stay in IDLE, outputs held.
- ISSUE:
  - Hold the asserted valid and the latched addr/data stable.
  - On the matching ready (wr_ready for a write, rd_ready for a read), deassert valid at that edge and go to WAIT.
  - The opposite-direction ready is ignored.
- WAIT:
  - On the matching done: pulse resp_done[g] for one cycle; resp_error <= wr_error or rd_error; for reads, resp_rdata <= rd_data (writes leave resp_rdata unchanged); go to IDLE.
  - The opposite-direction done is ignored.
- Re-arbitration: the earliest next grant is the cycle after resp_done. There is no back-to-back overlap, so the master is always idle when a valid is raised.
- Requester rules:
  - Keep req_valid and the command stable until req_ready.
  - Drop req_valid, or present a new command, in the cycle after req_ready.
  - req_valid raised during ISSUE/WAIT is held pending and arbitrated at the next IDLE.
- Fairness: a requester with continuous req_valid waits at most NUM_REQ-1 transactions.
- Simultaneous events: the requester leaving (req_ready) and a new request arriving in the same cycle are independent. resp_done and a new req_valid from the same requester in the same cycle are legal; that request is arbitrated in the following IDLE.
- Mid-operation reset: immediate return to reset values; the in-flight command is lost and no resp_done is issued. The master is reset by the same aresetn.
- Invalid state encoding: recover to IDLE with valids low.
- Grant decode: one-hot, at most one bit of req_ready or resp_done set in any cycle.

Optional Feature:
- Macro: AXIL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not used. Requester 0 can starve the others.
- Undefined (default): round-robin as described above.

Test Plan:
- Single write: req 1 issues we=1, addr=0x0000_0010, data=0xDEAD_BEEF.
  - Expect req_ready[1] one cycle later, then wr_valid with those values until wr_ready.
  - Model wr_done with bresp=00 → resp_done=3'b010, resp_error=00.
- Single read: req 2 issues addr=0x0000_0020; model returns rd_data=0x1234_5678, rresp=10 → resp_done[2] pulses, resp_rdata=0x1234_5678, resp_error=2'b10.
- Round-robin: all three requesters hold req_valid continuously for 6 transactions → grant order 0,1,2,0,1,2; no req_ready overlap.
- Fixed priority (macro defined): req 0 and req 2 both continuous → grants 0,0,0…; req 2 is granted only after req 0 deasserts.
- Stray handshakes: inject rd_done during a write WAIT → ignored; the write completes only on wr_done. Inject rd_ready during a write ISSUE → wr_valid is held.
- Reset in WAIT: aresetn low asynchronously mid-cycle → all outputs 0 immediately, no resp_done. After release, the pending req 0 is granted first.
